// File: rtl/bytewrite_sdp_ram_pipe_if.sv
// Port bundle for bytewrite_sdp_ram_pipe.
//   master : drives the write port (ena/wea/addra/dina) and read requests (enb/addrb),
//            observes init_done, dob, dob_valid
//   slave  : the RAM side
interface bytewrite_sdp_ram_pipe_if #(
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 12
);
    localparam int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH;

    logic                  init_done;
    logic                  ena;
    logic [NUM_COL-1:0]    wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic                  enb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] dob;
    logic                  dob_valid;

    modport master (
        input  init_done, dob, dob_valid,
        output ena, wea, addra, dina, enb, addrb
    );

    modport slave (
        output init_done, dob, dob_valid,
        input  ena, wea, addra, dina, enb, addrb
    );
endinterface

// File: rtl/bytewrite_sdp_ram_pipe.sv
// Column-write simple dual-port RAM (port A write, port B read) with a
// 1..3 stage read pipeline carrying a valid bit, and a post-reset clear
// sequencer that zeroes every word before user traffic is accepted.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset (does not touch RAM contents)
//   bus    : bytewrite_sdp_ram_pipe_if.slave
//            init_done, ena, wea, addra, dina, enb, addrb, dob, dob_valid
// Optional feature: define BWSDP_RAM_FWD_EN to forward written columns to a
// same-address, same-cycle read (write-first per column); otherwise read-first.
module bytewrite_sdp_ram_pipe #(
    parameter int unsigned NUM_COL       = 4,
    parameter int unsigned COL_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input logic                        clk,
    input logic                        rst_n,
    bytewrite_sdp_ram_pipe_if.slave    bus
);
    localparam int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    // Elaboration-time legality check on the read latency
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_rd_latency
        $error("bytewrite_sdp_ram_pipe: RD_LATENCY must be 1..3");
    end

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_init_done;

    logic                  w_clr_we;
    logic                  w_usr_wr;
    logic                  w_rd_en;
    logic [NUM_COL-1:0]    w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic [DATA_WIDTH-1:0] r_ram [DEPTH];
    logic [DATA_WIDTH-1:0] r_pd  [RD_LATENCY];
    logic [RD_LATENCY-1:0] r_pv;

    // Clear sequencer: walk every address once, then open the ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (INIT_ON_RESET == 0 || r_cnt == LAST_ADDR) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                ST_READY: r_init_done <= 1'b1;
                default: begin
                    r_state     <= ST_INIT;
                    r_cnt       <= '0;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    // Single write port shared by the clear sequencer and user port A
    assign w_clr_we = (r_state == ST_INIT) && (INIT_ON_RESET != 0);
    assign w_usr_wr = r_init_done && bus.ena;
    assign w_rd_en  = r_init_done && bus.enb;
    assign w_we     = w_clr_we ? {NUM_COL{1'b1}} : (w_usr_wr ? bus.wea : {NUM_COL{1'b0}});
    assign w_waddr  = w_clr_we ? r_cnt : bus.addra;
    assign w_wdata  = w_clr_we ? {DATA_WIDTH{1'b0}} : bus.dina;

    // RAM array: column-enabled write, no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_COL; i++) begin
            if (w_we[i]) begin
                r_ram[w_waddr][i*COL_WIDTH +: COL_WIDTH] <= w_wdata[i*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

`ifdef BWSDP_RAM_FWD_EN
    logic w_collide;

    // Same-cycle same-address hit: written columns bypass the array
    always_comb begin
        w_rd_word = r_ram[bus.addrb];
        w_collide = w_usr_wr && bus.enb && (bus.addra == bus.addrb);
        for (int i = 0; i < NUM_COL; i++) begin
            if (w_collide && bus.wea[i]) begin
                w_rd_word[i*COL_WIDTH +: COL_WIDTH] = bus.dina[i*COL_WIDTH +: COL_WIDTH];
            end
        end
    end
`else
    // Read-first: the array value before this edge's write
    assign w_rd_word = r_ram[bus.addrb];
`endif

    // Read pipeline; each stage loads only when a valid word moves into it,
    // so the output stage holds its last result between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_pd[k] <= '0;
            end
        end else begin
            r_pv[0] <= w_rd_en;
            if (w_rd_en) begin
                r_pd[0] <= w_rd_word;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_pv[k] <= r_pv[k-1];
                if (r_pv[k-1]) begin
                    r_pd[k] <= r_pd[k-1];
                end
            end
        end
    end

    assign bus.init_done = r_init_done;
    assign bus.dob       = r_pd[RD_LATENCY-1];
    assign bus.dob_valid = r_pv[RD_LATENCY-1];
endmodule

// File: tb/tb_bytewrite_sdp_ram_pipe.sv
// Directed bench for bytewrite_sdp_ram_pipe: one instance at RD_LATENCY=1,
// one at RD_LATENCY=3, sharing clock and reset.
module tb_bytewrite_sdp_ram_pipe;
    localparam int unsigned DEPTH = 4096;

`ifdef BWSDP_RAM_FWD_EN
    localparam logic [31:0] COLL_EXP = 32'hAAAA5555;
`else
    localparam logic [31:0] COLL_EXP = 32'hAAAAAAAA;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bytewrite_sdp_ram_pipe_if #(.NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(12)) if1 ();
    bytewrite_sdp_ram_pipe_if #(.NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(12)) if3 ();

    bytewrite_sdp_ram_pipe #(.RD_LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    bytewrite_sdp_ram_pipe #(.RD_LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if1.ena = 1'b0; if1.wea = '0; if1.addra = '0; if1.dina = '0;
        if1.enb = 1'b0; if1.addrb = '0;
        if3.ena = 1'b0; if3.wea = '0; if3.addra = '0; if3.dina = '0;
        if3.enb = 1'b0; if3.addrb = '0;
    endtask

    task automatic wr1(input logic [11:0] a, input logic [3:0] we, input logic [31:0] d);
        if1.ena = 1'b1; if1.addra = a; if1.wea = we; if1.dina = d;
        tick();
        if1.ena = 1'b0; if1.wea = '0;
    endtask

    // One read on the latency-1 instance; lat = edges from request to valid, -1 on timeout
    task automatic rd1(input logic [11:0] a, output logic [31:0] q, output int lat);
        if1.enb = 1'b1; if1.addrb = a;
        lat = -1; q = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if1.enb = 1'b0;
            if (if1.dob_valid === 1'b1) begin
                lat = c; q = if1.dob;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        idle_all();
        #23;
        total++; if (if1.init_done !== 1'b0) begin bad++; $display("FAIL rst_init_done1 got=%b exp=0", if1.init_done); end
        total++; if (if1.dob_valid !== 1'b0) begin bad++; $display("FAIL rst_valid1 got=%b exp=0", if1.dob_valid); end
        total++; if (if1.dob !== 32'h0) begin bad++; $display("FAIL rst_dob1 got=%h exp=0", if1.dob); end
        total++; if (if3.dob_valid !== 1'b0) begin bad++; $display("FAIL rst_valid3 got=%b exp=0", if3.dob_valid); end
        total++; if (if3.dob !== 32'h0) begin bad++; $display("FAIL rst_dob3 got=%h exp=0", if3.dob); end
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 5000; c++) begin
            tick();
            n++;
            if (if1.init_done === 1'b1) break;
        end
        total++; if (n != int'(DEPTH)) begin bad++; $display("FAIL init_edges got=%0d exp=%0d", n, DEPTH); end
        total++; if (if3.init_done !== 1'b1) begin bad++; $display("FAIL init_done3 got=%b exp=1", if3.init_done); end
    endtask

    task automatic test_init_zero();
        logic [31:0] q;
        int          lat;
        logic [11:0] addrs [3];
        addrs[0] = 12'h000; addrs[1] = 12'h7FF; addrs[2] = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            rd1(addrs[i], q, lat);
            total++; if (q !== 32'h0) begin bad++; $display("FAIL init_zero[%h] got=%h exp=0", addrs[i], q); end
            total++; if (lat != 1) begin bad++; $display("FAIL init_lat[%h] got=%0d exp=1", addrs[i], lat); end
        end
    endtask

    task automatic test_bytewrite();
        logic [31:0] q;
        int          lat;
        wr1(12'h010, 4'b1111, 32'hDEADBEEF);
        rd1(12'h010, q, lat);
        total++; if (q !== 32'hDEADBEEF) begin bad++; $display("FAIL full_write got=%h exp=deadbeef", q); end
        wr1(12'h010, 4'b0101, 32'h11223344);
        rd1(12'h010, q, lat);
        total++; if (q !== 32'hDE22BE44) begin bad++; $display("FAIL col_write got=%h exp=de22be44", q); end
        total++; if (lat != 1) begin bad++; $display("FAIL col_write_lat got=%0d exp=1", lat); end
        wr1(12'h011, 4'b0000, 32'hFFFFFFFF);
        rd1(12'h011, q, lat);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL wea_zero got=%h exp=0", q); end
        // dob holds the last result while no read completes
        tick();
        total++; if (if1.dob !== 32'h0 || if1.dob_valid !== 1'b0) begin bad++; $display("FAIL hold1 got=%h/%b exp=0/0", if1.dob, if1.dob_valid); end
    endtask

    task automatic test_pipeline3();
        logic exp_v;
        for (int i = 0; i < 5; i++) begin
            if3.ena = 1'b1; if3.wea = 4'b1111; if3.addra = 12'(i); if3.dina = 32'h1000_0000 + 32'(i);
            tick();
        end
        if3.ena = 1'b0; if3.wea = '0;
        for (int k = 0; k < 10; k++) begin
            if (k < 5) begin if3.enb = 1'b1; if3.addrb = 12'(k); end
            else if3.enb = 1'b0;
            tick();
            exp_v = (k >= 2 && k <= 6);
            total++; if (if3.dob_valid !== exp_v) begin bad++; $display("FAIL lat3_valid[%0d] got=%b exp=%b", k, if3.dob_valid, exp_v); end
            if (exp_v) begin
                total++;
                if (if3.dob !== 32'h1000_0000 + 32'(k-2)) begin
                    bad++; $display("FAIL lat3_data[%0d] got=%h exp=%h", k, if3.dob, 32'h1000_0000 + 32'(k-2));
                end
            end
        end
        total++; if (if3.dob !== 32'h1000_0004) begin bad++; $display("FAIL lat3_hold got=%h exp=10000004", if3.dob); end
    endtask

    task automatic test_collision();
        logic [31:0] q;
        int          lat;
        wr1(12'h020, 4'b1111, 32'hAAAAAAAA);
        if1.ena = 1'b1; if1.wea = 4'b0011; if1.addra = 12'h020; if1.dina = 32'h55555555;
        if1.enb = 1'b1; if1.addrb = 12'h020;
        tick();
        idle_all();
        total++; if (if1.dob_valid !== 1'b1) begin bad++; $display("FAIL coll_valid got=%b exp=1", if1.dob_valid); end
        total++; if (if1.dob !== COLL_EXP) begin bad++; $display("FAIL coll_data got=%h exp=%h", if1.dob, COLL_EXP); end
        rd1(12'h020, q, lat);
        total++; if (q !== 32'hAAAA5555) begin bad++; $display("FAIL coll_after got=%h exp=aaaa5555", q); end
    endtask

    task automatic test_reset_midflight();
        int          n;
        int          spurious;
        logic [31:0] q;
        int          lat;
        if3.enb = 1'b1; if3.addrb = 12'h000;
        tick();
        if3.addrb = 12'h001;
        tick();
        if3.enb = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (if3.dob_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", if3.dob_valid); end
        total++; if (if3.dob !== 32'h0) begin bad++; $display("FAIL midrst_dob got=%h exp=0", if3.dob); end
        total++; if (if1.init_done !== 1'b0) begin bad++; $display("FAIL midrst_init got=%b exp=0", if1.init_done); end
        spurious = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (if3.dob_valid !== 1'b0) spurious++;
        end
        rst_n = 1'b1;
        // Hammer both ports during the clear; all of it must be ignored
        if1.ena = 1'b1; if1.wea = 4'b1111; if1.addra = 12'h010; if1.dina = 32'hFFFFFFFF;
        if1.enb = 1'b1; if1.addrb = 12'h010;
        if3.ena = 1'b1; if3.wea = 4'b1111; if3.addra = 12'h001; if3.dina = 32'hFFFFFFFF;
        if3.enb = 1'b1; if3.addrb = 12'h001;
        n = 0;
        for (int c = 0; c < 5000; c++) begin
            tick();
            n++;
            if (if1.dob_valid !== 1'b0 || if3.dob_valid !== 1'b0) spurious++;
            if (if3.init_done === 1'b1) break;
        end
        idle_all();
        total++; if (n != int'(DEPTH)) begin bad++; $display("FAIL reinit_edges got=%0d exp=%0d", n, DEPTH); end
        total++; if (spurious != 0) begin bad++; $display("FAIL init_spurious_valid got=%0d exp=0", spurious); end
        rd1(12'h010, q, lat);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL init_ignored_wr got=%h exp=0", q); end
        if3.enb = 1'b1; if3.addrb = 12'h001;
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if3.enb = 1'b0;
            if (if3.dob_valid === 1'b1) begin lat = c; q = if3.dob; break; end
        end
        total++; if (lat != 3) begin bad++; $display("FAIL reinit_lat3 got=%0d exp=3", lat); end
        total++; if (q !== 32'h0) begin bad++; $display("FAIL reinit_data3 got=%h exp=0", q); end
    endtask

    initial begin
        test_reset();
        test_init_zero();
        test_bytewrite();
        test_pipeline3();
        test_collision();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
